// File: rtl/ysyx_22041412_pkg.sv
// Shared definitions for the NPC pipeline-stage register.
//   OCC_W         : width of the occupancy count (holds 0..2)
//   stage_state_e : stage fill state; the encoding equals the number of held beats
package ysyx_22041412_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/ysyx_22041412_pipe_ent.sv
// Single payload entry of a pipeline stage.
//   clk, rst : clock, asynchronous active-high reset (q <= RESET_VAL)
//   clr      : synchronous clear to RESET_VAL, takes priority over load
//   load     : capture d on the next rising edge
//   d, q     : payload in / held payload out
module ysyx_22041412_pipe_ent
  import ysyx_22041412_pkg::*;
#(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= RESET_VAL;
    else if (clr)  q <= RESET_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/ysyx_22041412_pipe_reg.sv
// Pipeline-stage register with valid/ready handshake, flush and optional
// two-entry skid buffer (SKID=1 registers in_ready to cut the ready path).
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : drop all held beats and the beat offered this cycle
//   in_valid/in_ready   : upstream handshake, in_data is the payload
//   out_valid/out_ready : downstream handshake, out_data is the payload
//   occupancy           : number of beats currently held
module ysyx_22041412_pipe_reg
  import ysyx_22041412_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  stage_state_e     state;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  // SKID=1 decodes in_ready purely from the state flops; SKID=0 lets a
  // draining downstream free the slot in the same cycle.
  assign in_ready  = SKID ? (state != ST_TWO) : ((state == ST_EMPTY) || out_ready);
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) state <= ST_ONE;
        ST_ONE: begin
          if (SKID && in_fire && !out_fire) state <= ST_TWO;
          else if (out_fire && !in_fire)    state <= ST_EMPTY;
        end
        ST_TWO:   if (out_fire) state <= ST_ONE;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // The main entry always feeds the output; it refills from the skid entry
  // when draining from TWO, otherwise straight from upstream.
  assign main_load = ((state == ST_EMPTY) && in_fire)
                  || ((state == ST_ONE) && in_fire && out_fire)
                  || ((state == ST_TWO) && out_fire);
  assign main_d    = (state == ST_TWO) ? skid_q : in_data;

  ysyx_22041412_pipe_ent #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (main_load),
    .d    (main_d),
    .q    (out_data)
  );

  if (SKID) begin : g_skid
    logic skid_load;
    assign skid_load = (state == ST_ONE) && in_fire && !out_fire;

    ysyx_22041412_pipe_ent #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .clr  (flush),
      .load (skid_load),
      .d    (in_data),
      .q    (skid_q)
    );
  end else begin : g_no_skid
    assign skid_q = RESET_VAL;
  end

endmodule

// File: doc/ysyx_22041412_pipe_reg.md
Name: ysyx_22041412_pipe_reg

Overview:
- Parametrised pipeline-stage register with a valid/ready handshake, flush, and an optional 2-entry skid buffer.
- Next generation of the plain enable register, used between NPC stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds back-pressure, bubble handling and wrong-path flush.
- With SKID=1, all outputs are registered, which breaks the ready path between stages.

Parameters:
- WIDTH, 32, payload width in bits (>=1)
- RESET_VAL, 0, value of out_data after reset and after a flush that empties the block
- SKID, 0, 0 = single-entry stage with combinational in_ready; 1 = two-entry skid buffer with registered in_ready

Ports:
- clk  input  1  single clock, all state updates on its rising edge
- rst  input  1  reset, asynchronous and active-high
- flush  input  1  discard all held beats and the beat offered this cycle
- in_valid  input  1  upstream beat offered
- in_ready  output  1  stage can accept a beat
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  downstream beat offered
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  downstream payload
- occupancy  output  2  number of beats held (0..1 for SKID=0, 0..2 for SKID=1)

Behaviour:
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Handshake rules are AXI-like.
  - out_data stays stable while out_valid=1 and out_ready=0.
  - out_valid never drops without out_fire or flush.
- Reset (async assert, sync release) sets out_valid=0, occupancy=0 and out_data=RESET_VAL.
  - With SKID=0, in_ready=1 during reset. With SKID=1, in_ready=1 during reset.
  - The skid entry is cleared to RESET_VAL.
  - Reset asserted mid-transfer aborts the beat; no beat is delivered after release.
- SKID=0 (states EMPTY, FULL):
  - in_ready = ~out_valid | out_ready. This is combinational from out_ready.
  - On in_fire, data is loaded next edge and out_valid=1.
  - On out_fire without in_fire, out_valid=0 next edge and out_data holds its last value.
  - Simultaneous in_fire and out_fire replaces the held beat. Throughput is 1 beat/cycle and latency is 1 cycle.
- SKID=1 (states EMPTY, ONE, TWO; main = output entry, skid = overflow entry):
  - in_ready = (state != TWO). This is a pure register output with no combinational path from out_ready.
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE, in_fire with no out_fire -> TWO, skid <= in_data.
  - ONE, in_fire and out_fire -> ONE, main <= in_data.
  - ONE, out_fire only -> EMPTY.
  - TWO: out_fire -> ONE, main <= skid. in_fire is impossible in TWO.
  - Order is strictly FIFO; no beat is dropped or duplicated. Steady-state throughput is 1 beat/cycle and latency is 1 cycle.
- Flush has priority over everything:
  - Next edge: state EMPTY, out_valid=0, occupancy=0, out_data=RESET_VAL.
  - A beat offered in the flush cycle counts as accepted if in_ready=1, then is discarded.
  - out_fire in the flush cycle still counts as delivered downstream, because out_valid was 1 that cycle.
- occupancy is registered and always equals the number of held beats.
- Width rules: payload is passed bit-exact with no truncation. RESET_VAL is zero-extended or truncated to WIDTH.

Decomposition:
- Shared package ysyx_22041412_pkg holds:
  - the stage-state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2)
  - the occupancy width constant
- One natural sub-module: ysyx_22041412_pipe_ent, a single WIDTH-bit entry with async reset, load enable and RESET_VAL.
  - Instantiated once for SKID=0 and twice for SKID=1.
  - Control FSM lives in the top module.

Test Plan:
- Reset: rst=1 mid-stream with out_valid=1 -> out_valid=0, out_data=RESET_VAL, occupancy=0 immediately (async). After release, the first beat 0xA5 appears one cycle after in_fire.
- Streaming: out_ready=1 constant, beats 1..16 on consecutive cycles -> out_data 1..16 on consecutive cycles, one cycle late. Both SKID values.
- Back-pressure, SKID=1: send 0x11, 0x22, 0x33 with out_ready=0 ->
  - in_ready drops after 0x22 is accepted; occupancy=2; 0x33 is held upstream.
  - out_ready=1 -> order 0x11, 0x22, 0x33, with no gaps once draining.
- Back-pressure, SKID=0: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 in the same cycle and the beat is replaced.
- Flush in TWO state while in_valid=1 -> next cycle out_valid=0, occupancy=0, out_data=RESET_VAL. Neither held beat nor the incoming beat is ever seen downstream.
- Random valid/ready with 10% flush over 10k cycles against a scoreboard model -> no loss, duplication or reorder. out_data is stable under stall.
